sdp_sched: RTL and testbench
============================

SDP_SCHED -- requirements
Module: sdp_sched

Interface
REQ-001 Parameter LAT, default 3, the fixed datapath latency in cycles from operand issue to valid dp_out; legal range 1..8.
REQ-002 Parameter INIT_CYC, default 4, the number of cycles dp_reset is held high after reset deasserts; legal range 1..15.
REQ-003 clk  input  1  sole clock, all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  3  per-requester request, one bit per requester, requesters 0..2.
REQ-006 req_ctl  input  6  per-requester control pair; bits [2i+1:2i] of requester i are {ctl_2, ctl_1}.
REQ-007 req_abc  input  9  per-requester operands; bits [3i+2:3i] of requester i are {c, b, a}.
REQ-008 drain  input  1  request to stop issuing and empty the pipeline.
REQ-009 dp_out  input  1  datapath result bit.
REQ-010 gnt  output  3  one-hot grant, combinational; the granted operation issues in that cycle.
REQ-011 dp_reset, dp_ctl_1, dp_ctl_2, dp_a, dp_b, dp_c  output  1 each  datapath reset and operand drive.
REQ-012 rsp_valid  output  1  result-valid strobe, registered.
REQ-013 rsp_id  output  2  requester id of the result, registered.
REQ-014 rsp_data  output  1  result bit, registered.
REQ-015 busy  output  1  high when any operation is in flight, registered.

Function
REQ-016 The FSM SHALL have four states: INIT, RUN, DRAIN and IDLE; reset enters INIT.
REQ-017 INIT: dp_reset=1 and gnt=0 for INIT_CYC cycles (cycle counter); then -> RUN.
REQ-018 RUN: dp_reset=0; gnt SHALL select the first requesting index at or after rr_ptr, modulo 3; gnt=0 when req=0.
REQ-019 rr_ptr: resets to 0; after a grant to i, rr_ptr <= (i+1) mod 3; unchanged when there is no grant.
REQ-020 When gnt[i]=1, dp_ctl_1/dp_ctl_2/dp_a/dp_b/dp_c SHALL equal requester i's fields in the same cycle; with no grant they SHALL all be 0.
REQ-021 In-flight tracker: a LAT-deep shift register of {valid, id}; stage 0 loads {|gnt, granted id} each cycle.
REQ-022 When the final stage is valid, the next cycle SHALL show rsp_valid=1, rsp_id=stored id and rsp_data=dp_out sampled in the cycle the final stage is valid; an issue at cycle t therefore responds with rsp_valid high at cycle t+LAT, and dp_out is sampled at cycle t+LAT-1.
REQ-023 Back-to-back issue SHALL be allowed in every RUN cycle; responses SHALL keep issue order with no gaps.
REQ-024 busy SHALL equal the OR of all tracker valid bits, registered.
REQ-025 RUN with drain=1: -> DRAIN; gnt=0 from that same cycle.
REQ-026 DRAIN: gnt=0; once every tracker valid bit is 0 -> IDLE; in-flight results SHALL still complete.
REQ-027 IDLE: gnt=0; drain=0 -> RUN; drain and req are ignored during INIT.
REQ-028 drain deasserting while in DRAIN SHALL NOT abort the drain; the FSM completes to IDLE first.
REQ-029 Requests SHALL NOT be latched: a requester holds req until it sees gnt, and a dropped req is simply not served.

Reset
REQ-030 When reset=1 at a posedge: FSM <= INIT, INIT counter <= 0, rr_ptr <= 0, tracker cleared, rsp_valid/rsp_id/rsp_data/busy <= 0.
REQ-031 During reset and INIT: dp_reset=1, gnt=0, dp_* operands=0.
REQ-032 Reset mid-operation SHALL discard all in-flight results; no rsp_valid is produced for them.

Verification
REQ-033 Reset, then idle -> dp_reset high for exactly 4 cycles; gnt=0 throughout; busy=0; RUN reached at cycle 5.
REQ-034 In RUN, req=3'b111 held for 6 cycles -> gnt sequence 001,010,100,001,010,100; rsp_valid on 6 consecutive cycles starting 3 cycles after the first grant; rsp_id sequence 0,1,2,0,1,2.
REQ-035 Only requester 1 requesting, fields {ctl=2'b10, abc=3'b101} -> the same cycle shows dp_ctl_2=1, dp_ctl_1=0, dp_c=1, dp_b=0, dp_a=1; a response follows 3 cycles later with rsp_id=1 and rsp_data equal to dp_out.
REQ-036 Two issues, then drain=1 for 1 cycle -> gnt=0 from the drain cycle; both responses still delivered; busy falls; IDLE reached; req ignored until drain=0 returns the FSM to RUN.
REQ-037 Reset asserted 1 cycle after an issue -> no rsp_valid for that issue, INIT re-entered, and rr_ptr=0 after INIT.
REQ-038 rr_ptr=2 with req=3'b011 -> gnt=001, and rr_ptr becomes 1.

Source files
------------

// File: rtl/sdp_sched.sv
// Round-robin scheduler for a fixed-latency datapath shared by three requesters.
// Issues one operation per RUN cycle and returns results in issue order.
module sdp_sched #(
   parameter int LAT      = 3,
   parameter int INIT_CYC = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req,
   input  logic [5:0] req_ctl,
   input  logic [8:0] req_abc,
   input  logic       drain,
   input  logic       dp_out,
   output logic [2:0] gnt,
   output logic       dp_reset,
   output logic       dp_ctl_1,
   output logic       dp_ctl_2,
   output logic       dp_a,
   output logic       dp_b,
   output logic       dp_c,
   output logic       rsp_valid,
   output logic [1:0] rsp_id,
   output logic       rsp_data,
   output logic       busy,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_IDLE  = 2'd3
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] ptr_q, ptr_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [1:0] rsp_id_q, rsp_id_d;
   logic       rsp_data_q, rsp_data_d;
   logic       busy_q, busy_d;

   logic [2:0] gnt_rr;
   logic [1:0] gnt_id;
   logic [1:0] idx;
   logic       issue;

   // Tracker view: stage 0 is the operation issuing this cycle, deeper stages are
   // registered, so the last stage lines up with the cycle dp_out is valid.
   logic [LAT-1:0]      stg_v;
   logic [LAT-1:0][1:0] stg_id;

   assign stg_v[0]  = issue;
   assign stg_id[0] = gnt_id;

   generate
      if (LAT > 1) begin : g_pipe
         logic [LAT-2:0]      v_q, v_d;
         logic [LAT-2:0][1:0] id_q, id_d;

         always_comb begin
            v_d  = stg_v[LAT-2:0];
            id_d = stg_id[LAT-2:0];
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               v_q  <= '0;
               id_q <= '0;
            end else begin
               v_q  <= v_d;
               id_q <= id_d;
            end
         end

         assign stg_v[LAT-1:1]  = v_q;
         assign stg_id[LAT-1:1] = id_q;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         ptr_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            if (cnt_q == 4'(INIT_CYC - 1)) state_d = ST_RUN;
            else                           cnt_d   = cnt_q + 4'd1;
         end
         ST_RUN:   if (drain)   state_d = ST_DRAIN;
         // Leaving DRAIN depends only on the pipeline emptying, not on drain.
         ST_DRAIN: if (~|stg_v) state_d = ST_IDLE;
         ST_IDLE:  if (!drain)  state_d = ST_RUN;
         default:  state_d = ST_INIT;
      endcase
   end

   always_comb begin
      gnt_rr = '0;
      gnt_id = '0;
      idx    = '0;
      // Walk from the farthest offset down so the nearest requester at/after ptr wins.
      for (int k = 2; k >= 0; k--) begin
         idx = 2'((int'(ptr_q) + k) % 3);
         if (req[idx]) begin
            gnt_rr = 3'b001 << idx;
            gnt_id = idx;
         end
      end

      gnt   = (!reset && state_q == ST_RUN && !drain) ? gnt_rr : 3'b000;
      issue = |gnt;

      {dp_ctl_2, dp_ctl_1} = 2'b00;
      {dp_c, dp_b, dp_a}   = 3'b000;
      if (issue) begin
         {dp_ctl_2, dp_ctl_1} = req_ctl[2*gnt_id +: 2];
         {dp_c, dp_b, dp_a}   = req_abc[3*gnt_id +: 3];
      end

      dp_reset  = reset || (state_q == ST_INIT);
      state_dbg = state_q;
      rsp_valid = rsp_valid_q;
      rsp_id    = rsp_id_q;
      rsp_data  = rsp_data_q;
      busy      = busy_q;
   end

   always_comb begin
      ptr_d       = issue ? ((gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1) : ptr_q;
      rsp_valid_d = stg_v[LAT-1];
      rsp_id_d    = stg_id[LAT-1];
      rsp_data_d  = dp_out;
      busy_d      = |stg_v;
   end

endmodule

// File: tb/tb_sdp_sched.sv
// Directed bench for sdp_sched: reset/INIT, round-robin order, operand steering,
// response latency, drain/idle sequencing and mid-flight reset.
module tb_sdp_sched;

   logic       clk;
   logic       reset;
   logic [2:0] req;
   logic [5:0] req_ctl;
   logic [8:0] req_abc;
   logic       drain;
   logic       dp_out;
   logic [2:0] gnt;
   logic       dp_reset, dp_ctl_1, dp_ctl_2, dp_a, dp_b, dp_c;
   logic       rsp_valid;
   logic [1:0] rsp_id;
   logic       rsp_data;
   logic       busy;
   logic [1:0] state_dbg;
   logic [4:0] dut_ops;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [1:0] S_INIT = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_IDLE = 2'd3;

   assign dut_ops = {dp_ctl_2, dp_ctl_1, dp_c, dp_b, dp_a};

   sdp_sched #(.LAT(3), .INIT_CYC(4)) dut (
      .clk(clk), .reset(reset), .req(req), .req_ctl(req_ctl), .req_abc(req_abc),
      .drain(drain), .dp_out(dp_out), .gnt(gnt), .dp_reset(dp_reset),
      .dp_ctl_1(dp_ctl_1), .dp_ctl_2(dp_ctl_2), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy),
      .state_dbg(state_dbg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = '0; req_ctl = '0; req_abc = '0; drain = 1'b0; dp_out = 1'b0;
      tick(); tick();
      @(negedge clk);
      n_checks++;
      if (dp_reset !== 1'b1 || gnt !== 3'b000 || rsp_valid !== 1'b0 || busy !== 1'b0 || state_dbg !== S_INIT)
         $display("FAIL reset_hold: dp_reset=%b gnt=%b rsp_valid=%b busy=%b state=%0d expected 1 000 0 0 0",
                  dp_reset, gnt, rsp_valid, busy, state_dbg);
      else n_pass++;
      tick();
      reset = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         req     = (c < 5) ? 3'b111 : 3'b000;
         drain   = (c < 5);
         req_abc = 9'h1ff;
         req_ctl = 6'h3f;
         @(negedge clk);
         n_checks++;
         if (c < 5) begin
            if (dp_reset !== 1'b1 || gnt !== 3'b000 || dut_ops !== 5'b0 || busy !== 1'b0 || state_dbg !== S_INIT)
               $display("FAIL init_cyc%0d: dp_reset=%b gnt=%b ops=%b busy=%b state=%0d expected 1 000 00000 0 0",
                        c, dp_reset, gnt, dut_ops, busy, state_dbg);
            else n_pass++;
         end else begin
            if (dp_reset !== 1'b0 || gnt !== 3'b000 || state_dbg !== S_RUN)
               $display("FAIL run_at_cyc5: dp_reset=%b gnt=%b state=%0d expected 0 000 1",
                        dp_reset, gnt, state_dbg);
            else n_pass++;
         end
         tick();
      end
      drain = 1'b0;
   endtask

   task automatic test_rr_all();
      logic [11:0] dp_pat;
      logic [4:0]  ops_tab [3];
      logic [2:0]  exp_gnt;
      logic [4:0]  exp_ops;
      dp_pat     = 12'b0110_1011_0010;
      ops_tab[0] = 5'b11101;
      ops_tab[1] = 5'b01011;
      ops_tab[2] = 5'b10110;
      req_ctl = 6'b10_01_11;
      req_abc = 9'b110_011_101;
      for (int c = 0; c < 12; c++) begin
         req    = (c < 6) ? 3'b111 : 3'b000;
         dp_out = dp_pat[c];
         @(negedge clk);
         exp_gnt = (c < 6) ? (3'b001 << (c % 3)) : 3'b000;
         exp_ops = (c < 6) ? ops_tab[c % 3] : 5'b00000;
         n_checks++;
         if (gnt !== exp_gnt || dut_ops !== exp_ops)
            $display("FAIL rr_all_gnt c%0d: gnt=%b ops=%b expected %b %b", c, gnt, dut_ops, exp_gnt, exp_ops);
         else n_pass++;
         n_checks++;
         if (c >= 3 && c < 9) begin
            if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 3) % 3) || rsp_data !== dp_pat[c-1])
               $display("FAIL rr_all_rsp c%0d: valid=%b id=%0d data=%b expected 1 %0d %b",
                        c, rsp_valid, rsp_id, rsp_data, (c - 3) % 3, dp_pat[c-1]);
            else n_pass++;
         end else begin
            if (rsp_valid !== 1'b0)
               $display("FAIL rr_all_norsp c%0d: valid=%b expected 0", c, rsp_valid);
            else n_pass++;
         end
         if (c == 4 || c == 11) begin
            n_checks++;
            if (busy !== (c == 4))
               $display("FAIL rr_all_busy c%0d: busy=%b expected %b", c, busy, (c == 4));
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_single();
      req_ctl = 6'b11_10_11;
      req_abc = 9'b111_101_111;
      for (int c = 0; c < 5; c++) begin
         req    = (c == 0) ? 3'b010 : 3'b000;
         dp_out = (c == 2);
         @(negedge clk);
         if (c == 0) begin
            n_checks++;
            if (gnt !== 3'b010 || dut_ops !== 5'b10101)
               $display("FAIL single_issue: gnt=%b ops=%b expected 010 10101", gnt, dut_ops);
            else n_pass++;
         end
         n_checks++;
         if (c == 3) begin
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 1'b1)
               $display("FAIL single_rsp: valid=%b id=%0d data=%b expected 1 1 1", rsp_valid, rsp_id, rsp_data);
            else n_pass++;
         end else begin
            if (rsp_valid !== 1'b0)
               $display("FAIL single_norsp c%0d: valid=%b expected 0", c, rsp_valid);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_rr_wrap();
      // Pointer sits at 2 after the previous grant to requester 1.
      for (int c = 0; c < 6; c++) begin
         req    = (c < 2) ? 3'b011 : 3'b000;
         dp_out = (c == 3);
         @(negedge clk);
         if (c < 2) begin
            n_checks++;
            if (gnt !== ((c == 0) ? 3'b001 : 3'b010))
               $display("FAIL wrap_gnt c%0d: gnt=%b expected %b", c, gnt, (c == 0) ? 3'b001 : 3'b010);
            else n_pass++;
         end
         if (c == 3 || c == 4) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(c - 3) || rsp_data !== (c == 4))
               $display("FAIL wrap_rsp c%0d: valid=%b id=%0d data=%b expected 1 %0d %b",
                        c, rsp_valid, rsp_id, rsp_data, c - 3, (c == 4));
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_drain();
      logic [2:0] exp_gnt;
      logic [1:0] exp_st;
      for (int c = 0; c < 9; c++) begin
         req    = 3'b111;
         drain  = (c == 2) || (c == 5) || (c == 6);
         dp_out = (c == 3);
         @(negedge clk);
         case (c)
            0:       exp_gnt = 3'b100;
            1:       exp_gnt = 3'b001;
            8:       exp_gnt = 3'b010;
            default: exp_gnt = 3'b000;
         endcase
         if (c <= 2 || c == 8) exp_st = S_RUN;
         else if (c <= 4)      exp_st = S_DRAIN;
         else                  exp_st = S_IDLE;
         n_checks++;
         if (gnt !== exp_gnt || state_dbg !== exp_st)
            $display("FAIL drain_seq c%0d: gnt=%b state=%0d expected %b %0d", c, gnt, state_dbg, exp_gnt, exp_st);
         else n_pass++;
         if (c == 3 || c == 4) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== ((c == 3) ? 2'd2 : 2'd0) || rsp_data !== (c == 4))
               $display("FAIL drain_rsp c%0d: valid=%b id=%0d data=%b expected 1 %0d %b",
                        c, rsp_valid, rsp_id, rsp_data, (c == 3) ? 2 : 0, (c == 4));
            else n_pass++;
         end
         if (c == 3 || c == 5) begin
            n_checks++;
            if (busy !== (c == 3))
               $display("FAIL drain_busy c%0d: busy=%b expected %b", c, busy, (c == 3));
            else n_pass++;
         end
         tick();
      end
      req = 3'b000; drain = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 7; c++) begin
         req   = (c == 0 || c == 6) ? ((c == 0) ? 3'b001 : 3'b111) : 3'b000;
         reset = (c == 1);
         @(negedge clk);
         if (c == 0 || c == 6) begin
            n_checks++;
            if (gnt !== 3'b001)
               $display("FAIL rstmid_gnt c%0d: gnt=%b expected 001", c, gnt);
            else n_pass++;
         end else begin
            n_checks++;
            if (rsp_valid !== 1'b0 || dp_reset !== 1'b1 || gnt !== 3'b000 ||
                (c >= 2 && state_dbg !== S_INIT))
               $display("FAIL rstmid_init c%0d: valid=%b dp_reset=%b gnt=%b state=%0d expected 0 1 000 0",
                        c, rsp_valid, dp_reset, gnt, state_dbg);
            else n_pass++;
         end
         tick();
      end
      req = 3'b000;
   endtask

   initial begin
      test_reset();
      test_rr_all();
      test_single();
      test_rr_wrap();
      test_drain();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
